// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow, registered read data with valid strobe, and sync flush.
module fifo_sync_param #(
    parameter int DATA_W   = 9,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    input  logic              err_clr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic              overflow,
    output logic              underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              rd_acc, wr_acc, ovf_set, udf_set;

    // Flags decode only the registered count, so no request reaches an output combinationally.
    assign full         = (count == (AW+1)'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= (AW+1)'(AF_LEVEL));
    assign almost_empty = (count <= (AW+1)'(AE_LEVEL));

    // Flush swallows every request in its cycle, including error detection.
    assign rd_acc  = rd_en & ~empty & ~flush;
    assign wr_acc  = wr_en & (~full | rd_acc) & ~flush;
    assign ovf_set = wr_en & full & ~rd_acc & ~flush;
    assign udf_set = rd_en & empty & ~flush;

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            overflow   <= ovf_set | (overflow & ~err_clr);
            underflow  <= udf_set | (underflow & ~err_clr);
            dout_valid <= rd_acc;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_acc)
                    wr_ptr <= wr_ptr + 1'b1;
                if (rd_acc) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    dout   <= mem[rd_ptr[AW-1:0]];
                end
                case ({wr_acc, rd_acc})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomized and directed bench for fifo_sync_param against a queue-based reference model.
module tb_fifo_sync_param;
    localparam int DATA_W = 9;
    localparam int DEPTH  = 8;
    localparam int AF     = 6;
    localparam int AE     = 2;

    logic              clk = 1'b0;
    logic              rst, flush, wr_en, rd_en, err_clr;
    logic [DATA_W-1:0] din, dout;
    logic              dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0]        count;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_dout;
    bit                m_vld, m_ovf, m_udf;

    fifo_sync_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .err_clr(err_clr), .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_vld  = 0;
        m_ovf  = 0;
        m_udf  = 0;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, int'(count), n);
        chk({tag, ".full"}, int'(full), int'(n == DEPTH));
        chk({tag, ".empty"}, int'(empty), int'(n == 0));
        chk({tag, ".afull"}, int'(almost_full), int'(n >= AF));
        chk({tag, ".aempty"}, int'(almost_empty), int'(n <= AE));
        chk({tag, ".dvalid"}, int'(dout_valid), int'(m_vld));
        chk({tag, ".dout"}, int'(dout), int'(m_dout));
        chk({tag, ".ovf"}, int'(overflow), int'(m_ovf));
        chk({tag, ".udf"}, int'(underflow), int'(m_udf));
    endtask

    // One clock: drive, advance model by the FIFO rules, then compare.
    task automatic step(input string tag, input bit f, input bit w, input logic [DATA_W-1:0] d,
                        input bit r, input bit c);
        bit rd_ok, wr_ok, ov, ud;
        flush = f; wr_en = w; din = d; rd_en = r; err_clr = c;
        @(posedge clk);
        ov = 0; ud = 0; m_vld = 0;
        if (f) q.delete();
        else begin
            rd_ok = r && (q.size() > 0);
            wr_ok = w && (q.size() < DEPTH || rd_ok);
            ov    = w && !wr_ok;
            ud    = r && (q.size() == 0);
            if (rd_ok) begin m_dout = q.pop_front(); m_vld = 1; end
            if (wr_ok) q.push_back(d);
        end
        m_ovf = ov | (m_ovf & !c);
        m_udf = ud | (m_udf & !c);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; flush = 0; wr_en = 0; rd_en = 0; err_clr = 0; din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // 1: fill
        for (int i = 0; i < DEPTH; i++) step("t1_wr", 0, 1, DATA_W'(9'h101 + i), 0, 0);
        chk("t1_full", int'(full), 1);
        chk("t1_count", int'(count), 8);

        // 2: drain, explicit order
        for (int i = 0; i < DEPTH; i++) begin
            step("t2_rd", 0, 0, '0, 1, 0);
            chk("t2_dout", int'(dout), 'h101 + i);
        end
        chk("t2_empty", int'(empty), 1);

        // 3: overflow then clear
        for (int i = 0; i < DEPTH; i++) step("t3_fill", 0, 1, DATA_W'(9'h020 + i), 0, 0);
        step("t3_ovf", 0, 1, 9'h1FF, 0, 0);
        chk("t3_ovf_set", int'(overflow), 1);
        step("t3_clr", 0, 0, '0, 0, 1);
        chk("t3_ovf_clr", int'(overflow), 0);

        // 4: full with simultaneous read/write, wraps pointers
        for (int i = 0; i < 20; i++) step("t4_rw", 0, 1, DATA_W'(9'h140 + i), 1, 0);
        chk("t4_count", int'(count), 8);
        for (int i = 0; i < DEPTH; i++) step("t4_drain", 0, 0, '0, 1, 0);

        // 5: underflow, then simultaneous on empty
        step("t5_udf", 0, 0, '0, 1, 0);
        chk("t5_udf_set", int'(underflow), 1);
        step("t5_rw", 0, 1, 9'h0AA, 1, 0);
        chk("t5_count", int'(count), 1);
        step("t5_clr", 0, 0, '0, 1, 1);

        // 6: flush with write, then async reset mid-stream
        for (int i = 0; i < 4; i++) step("t6_wr", 0, 1, DATA_W'(9'h060 + i), 0, 0);
        step("t6_pre", 0, 1, 9'h064, 0, 0);
        chk("t6_count5", int'(count), 5);
        step("t6_flush", 1, 1, 9'h065, 0, 0);
        chk("t6_flush_cnt", int'(count), 0);
        for (int i = 0; i < DEPTH; i++) step("t6_refill", 0, 1, DATA_W'(9'h070 + i), i == 7, 0);
        step("t6_ovf", 0, 1, 9'h0FF, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t6_async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;

        // random traffic with alternating fill/drain bias
        for (int i = 0; i < 800; i++) begin
            int wp, rp;
            bit f, c;
            wp = ((i / 100) % 2) ? 80 : 35;
            rp = ((i / 100) % 2) ? 35 : 80;
            f  = ($urandom_range(0, 59) == 0);
            c  = !f && ($urandom_range(0, 15) == 0);
            step("rand", f, $urandom_range(0, 99) < wp, DATA_W'($urandom), $urandom_range(0, 99) < rp, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
